// File: rtl/window_addr_gen.sv
// window_addr_gen: 2-D strided address generator for feature-map window scans.
// Walks col 0..Cols and row 0..Rows (both inclusive) and produces
// Addr = Base + row*RowPitch + col*Stride using adders only: the column
// step adds Stride to the running address, and the row step adds RowPitch
// to a separately kept row base address.
//
// Handshake: Start is a request sampled only in IDLE; it latches the whole
// configuration and the first address is presented (with Busy=1) on the
// next cycle. While Busy, Step acts as "consumer took the current Addr";
// each rising edge with Step=1 advances one position, and the edge that
// consumes the Last position raises Done for one cycle and drops Busy.
// Abort cancels a running scan and wins over Step.
module window_addr_gen #(
   parameter int BITWIDTH   = 10,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  WINDOW_ADDR_GEN_Clk,
   input  logic                  WINDOW_ADDR_GEN_Clr,
   input  logic                  WINDOW_ADDR_GEN_Start,
   input  logic                  WINDOW_ADDR_GEN_Step,
   input  logic                  WINDOW_ADDR_GEN_Abort,
   input  logic [BITWIDTH-1:0]   WINDOW_ADDR_GEN_Cols,
   input  logic [BITWIDTH-1:0]   WINDOW_ADDR_GEN_Rows,
   input  logic [ADDR_WIDTH-1:0] WINDOW_ADDR_GEN_Base,
   input  logic [ADDR_WIDTH-1:0] WINDOW_ADDR_GEN_Stride,
   input  logic [ADDR_WIDTH-1:0] WINDOW_ADDR_GEN_RowPitch,
   output logic [ADDR_WIDTH-1:0] WINDOW_ADDR_GEN_Addr,
   output logic [BITWIDTH-1:0]   WINDOW_ADDR_GEN_Col,
   output logic [BITWIDTH-1:0]   WINDOW_ADDR_GEN_Row,
   output logic                  WINDOW_ADDR_GEN_Busy,
   output logic                  WINDOW_ADDR_GEN_Last,
   output logic                  WINDOW_ADDR_GEN_Done
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [BITWIDTH-1:0]   cols_l_q, cols_l_d;
   logic [BITWIDTH-1:0]   rows_l_q, rows_l_d;
   logic [ADDR_WIDTH-1:0] base_l_q, base_l_d;
   logic [ADDR_WIDTH-1:0] stride_l_q, stride_l_d;
   logic [ADDR_WIDTH-1:0] pitch_l_q, pitch_l_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [BITWIDTH-1:0]   col_q, col_d;
   logic [BITWIDTH-1:0]   row_q, row_d;
   logic                  done_q, done_d;
   logic                  last_w;

   // Final position of the latched window while a scan is active.
   always_comb begin
      last_w = (state_q == ST_RUN) && (col_q == cols_l_q) && (row_q == rows_l_q);
   end

   // Next-state and datapath: hold everything by default, then apply the
   // single action selected by state and the Start/Abort/Step qualifiers.
   always_comb begin
      state_d    = state_q;
      cols_l_d   = cols_l_q;
      rows_l_d   = rows_l_q;
      base_l_d   = base_l_q;
      stride_l_d = stride_l_q;
      pitch_l_d  = pitch_l_q;
      addr_d     = addr_q;
      row_base_d = row_base_q;
      col_d      = col_q;
      row_d      = row_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (WINDOW_ADDR_GEN_Start) begin
               cols_l_d   = WINDOW_ADDR_GEN_Cols;
               rows_l_d   = WINDOW_ADDR_GEN_Rows;
               base_l_d   = WINDOW_ADDR_GEN_Base;
               stride_l_d = WINDOW_ADDR_GEN_Stride;
               pitch_l_d  = WINDOW_ADDR_GEN_RowPitch;
               col_d      = '0;
               row_d      = '0;
               addr_d     = WINDOW_ADDR_GEN_Base;
               row_base_d = WINDOW_ADDR_GEN_Base;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (WINDOW_ADDR_GEN_Abort) begin
               state_d = ST_IDLE;
            end else if (WINDOW_ADDR_GEN_Step) begin
               if (col_q < cols_l_q) begin
                  col_d  = col_q + 1'b1;
                  addr_d = addr_q + stride_l_q;
               end else if (row_q < rows_l_q) begin
                  col_d      = '0;
                  row_d      = row_q + 1'b1;
                  row_base_d = row_base_q + pitch_l_q;
                  addr_d     = row_base_q + pitch_l_q;
               end else begin
                  // Final position consumed: indices and address hold.
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge WINDOW_ADDR_GEN_Clk or negedge WINDOW_ADDR_GEN_Clr) begin
      if (!WINDOW_ADDR_GEN_Clr) begin
         state_q    <= ST_IDLE;
         cols_l_q   <= '0;
         rows_l_q   <= '0;
         base_l_q   <= '0;
         stride_l_q <= '0;
         pitch_l_q  <= '0;
         addr_q     <= '0;
         row_base_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cols_l_q   <= cols_l_d;
         rows_l_q   <= rows_l_d;
         base_l_q   <= base_l_d;
         stride_l_q <= stride_l_d;
         pitch_l_q  <= pitch_l_d;
         addr_q     <= addr_d;
         row_base_q <= row_base_d;
         col_q      <= col_d;
         row_q      <= row_d;
         done_q     <= done_d;
      end
   end

   // Output drive; Busy is simply the RUN state.
   always_comb begin
      WINDOW_ADDR_GEN_Addr = addr_q;
      WINDOW_ADDR_GEN_Col  = col_q;
      WINDOW_ADDR_GEN_Row  = row_q;
      WINDOW_ADDR_GEN_Busy = (state_q == ST_RUN);
      WINDOW_ADDR_GEN_Last = last_w;
      WINDOW_ADDR_GEN_Done = done_q;
   end

endmodule

// File: tb/tb_window_addr_gen.sv
// Testbench for window_addr_gen: directed scenarios followed by randomized
// traffic, every output compared each cycle against a position-based model
// that computes the address directly as Base + row*RowPitch + col*Stride.
module tb_window_addr_gen;

   localparam int BW = 10;
   localparam int AW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          start, step, abort;
   logic [BW-1:0] cols, rows;
   logic [AW-1:0] base, stride, pitch;
   logic [AW-1:0] addr;
   logic [BW-1:0] col, row;
   logic          busy, last, done;

   window_addr_gen #(.BITWIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .WINDOW_ADDR_GEN_Clk      (clk),
      .WINDOW_ADDR_GEN_Clr      (rst_n),
      .WINDOW_ADDR_GEN_Start    (start),
      .WINDOW_ADDR_GEN_Step     (step),
      .WINDOW_ADDR_GEN_Abort    (abort),
      .WINDOW_ADDR_GEN_Cols     (cols),
      .WINDOW_ADDR_GEN_Rows     (rows),
      .WINDOW_ADDR_GEN_Base     (base),
      .WINDOW_ADDR_GEN_Stride   (stride),
      .WINDOW_ADDR_GEN_RowPitch (pitch),
      .WINDOW_ADDR_GEN_Addr     (addr),
      .WINDOW_ADDR_GEN_Col      (col),
      .WINDOW_ADDR_GEN_Row      (row),
      .WINDOW_ADDR_GEN_Busy     (busy),
      .WINDOW_ADDR_GEN_Last     (last),
      .WINDOW_ADDR_GEN_Done     (done)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   int unsigned m_cols, m_rows, m_base, m_stride, m_pitch;
   int unsigned m_col, m_row;
   bit          m_busy, m_done;

   task automatic model_reset();
      m_cols = 0; m_rows = 0; m_base = 0; m_stride = 0; m_pitch = 0;
      m_col = 0; m_row = 0; m_busy = 0; m_done = 0;
   endtask

   // One rising edge worth of behaviour, from the currently driven inputs.
   task automatic model_clock();
      m_done = 0;
      if (!m_busy) begin
         if (start) begin
            m_cols = cols; m_rows = rows; m_base = base;
            m_stride = stride; m_pitch = pitch;
            m_col = 0; m_row = 0; m_busy = 1;
         end
      end else if (abort) begin
         m_busy = 0;
      end else if (step) begin
         if (m_col < m_cols) m_col++;
         else if (m_row < m_rows) begin m_col = 0; m_row++; end
         else begin m_busy = 0; m_done = 1; end
      end
   endtask

   function automatic int unsigned model_addr();
      return (m_base + m_row * m_pitch + m_col * m_stride) & 32'hFFFF;
   endfunction

   // ---------------- scoreboard ----------------
   logic [AW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/addr"}, 32'(addr), model_addr());
      chk({tag, "/col"},  32'(col),  m_col);
      chk({tag, "/row"},  32'(row),  m_row);
      chk({tag, "/busy"}, 32'(busy), 32'(m_busy));
      chk({tag, "/last"}, 32'(last), 32'(m_busy && m_col == m_cols && m_row == m_rows));
      chk({tag, "/done"}, 32'(done), 32'(m_done));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
   endtask

   task automatic set_cfg(input int unsigned c, input int unsigned r, input int unsigned b,
                          input int unsigned s, input int unsigned p);
      cols = BW'(c); rows = BW'(r); base = AW'(b); stride = AW'(s); pitch = AW'(p);
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      cycle(tag);
      start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      start = 0; step = 0; abort = 0;
      set_cfg(0, 0, 0, 0, 0);
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // Basic scan with explicit address list.
      set_cfg(2, 1, 100, 2, 20);
      exp_q = {16'd100, 16'd102, 16'd104, 16'd120, 16'd122, 16'd124};
      do_start("basic_start");
      step = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("basic_seq", 32'(addr), 32'(exp_q.pop_front()));
         if (i == 5) chk("basic_last", 32'(last), 32'd1);
         cycle("basic");
      end
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_busy", 32'(busy), 32'd0);
      step = 1'b0;
      cycle("idle_hold");

      // Step gaps with a mid-scan configuration change.
      do_start("gap_start");
      for (int i = 0; i < 14; i++) begin
         step = i[0];
         if (i == 3) set_cfg(5, 5, 16'h4000, 9, 77);
         cycle("gap");
      end
      step = 1'b0;
      cycle("gap_tail");

      // Single-position scan.
      set_cfg(0, 0, 7, 3, 5);
      do_start("single_start");
      chk("single_addr", 32'(addr), 32'd7);
      chk("single_last", 32'(last), 32'd1);
      step = 1'b1;
      cycle("single_step");
      chk("single_done", 32'(done), 32'd1);
      step = 1'b0;

      // Address wrap.
      set_cfg(3, 0, 16'hFFFE, 1, 0);
      exp_q = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      do_start("wrap_start");
      step = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_seq", 32'(addr), 32'(exp_q.pop_front()));
         cycle("wrap");
      end
      step = 1'b0;

      // Abort together with Step at position (1,0), then restart.
      set_cfg(2, 1, 100, 2, 20);
      do_start("abort_start");
      step = 1'b1;
      cycle("abort_pre");
      abort = 1'b1;
      cycle("abort");
      chk("abort_busy", 32'(busy), 32'd0);
      abort = 1'b0; step = 1'b0;
      cycle("abort_idle");
      abort = 1'b1;
      cycle("abort_in_idle");
      do_start("restart");
      abort = 1'b0;
      chk("restart_addr", 32'(addr), 32'd100);

      // Start during RUN is ignored; back-to-back scans.
      step = 1'b1;
      cycle("run");
      set_cfg(1, 1, 500, 1, 10);
      start = 1'b1;
      cycle("start_in_run");
      start = 1'b0;
      while (m_busy) cycle("finish_scan");
      start = 1'b1;
      step = 1'b0;
      cycle("b2b_start");
      chk("b2b_addr", 32'(addr), 32'd500);
      start = 1'b0;
      step = 1'b1;
      for (int i = 0; i < 4; i++) cycle("b2b");
      chk("b2b_done", 32'(done), 32'd1);
      step = 1'b0;

      // Asynchronous reset mid-scan.
      set_cfg(3, 2, 300, 4, 40);
      do_start("rst_start");
      step = 1'b1;
      cycle("rst_run");
      cycle("rst_run");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle("post_reset_step");
      step = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         step  = ($urandom_range(0, 9) < 7);
         abort = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 5) == 0);
         set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                 $urandom_range(0, 65535), $urandom_range(0, 65535));
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/window_addr_gen.md
Name: window_addr_gen

Overview:
- Parametrised successor to the single-offset counter: a 2-D strided address generator for scanning feature-map windows.
- Walks a column index 0..Cols and a row index 0..Rows, both bounds inclusive, and emits an address.
- Address = Base + row*RowPitch + col*Stride, built incrementally with adders only, no multipliers.
- Sits between the accelerator control FSM and the feature-map/weight memories; one instance per address stream.

Parameters:
- BITWIDTH, 10, width of column/row indices and of the Cols/Rows bounds.
- ADDR_WIDTH, 16, width of Base, Stride, RowPitch and the output address.

Ports:
- WINDOW_ADDR_GEN_Clk  input  1  clock; all state updates on the rising edge.
- WINDOW_ADDR_GEN_Clr  input  1  asynchronous active-low reset.
- WINDOW_ADDR_GEN_Start  input  1  single-cycle request; latches configuration and begins a scan.
- WINDOW_ADDR_GEN_Step  input  1  advance to the next position while busy.
- WINDOW_ADDR_GEN_Abort  input  1  synchronous cancel of the scan in progress.
- WINDOW_ADDR_GEN_Cols  input  BITWIDTH  last column index (inclusive).
- WINDOW_ADDR_GEN_Rows  input  BITWIDTH  last row index (inclusive).
- WINDOW_ADDR_GEN_Base  input  ADDR_WIDTH  start address.
- WINDOW_ADDR_GEN_Stride  input  ADDR_WIDTH  address increment per column.
- WINDOW_ADDR_GEN_RowPitch  input  ADDR_WIDTH  address increment per row.
- WINDOW_ADDR_GEN_Addr  output  ADDR_WIDTH  current address; registered.
- WINDOW_ADDR_GEN_Col  output  BITWIDTH  current column index.
- WINDOW_ADDR_GEN_Row  output  BITWIDTH  current row index.
- WINDOW_ADDR_GEN_Busy  output  1  high while a scan is active; Addr is valid while Busy.
- WINDOW_ADDR_GEN_Last  output  1  combinational; high when Busy and col==Cols_l and row==Rows_l.
- WINDOW_ADDR_GEN_Done  output  1  one-cycle pulse when the final position is consumed.

Behaviour:
- Reset (Clr low, asynchronous): state IDLE; Addr, Col, Row, row_base and latched configuration all 0; Busy, Done 0.
- FSM has two states: IDLE and RUN.
- IDLE, Start=1:
  - Latch Cols/Rows/Base/Stride/RowPitch into Cols_l/Rows_l/etc.
  - Col=0, Row=0, Addr=Base, row_base=Base.
  - Go to RUN; Busy=1 from the next cycle.
  - Latency Start -> first valid Addr is 1 cycle.
- IDLE: Step ignored; outputs hold their last values.
- RUN: Start ignored. Configuration inputs may change freely; only the latched copies are used.
- RUN, Step=1, col<Cols_l: Col+1; Addr+=Stride_l.
- RUN, Step=1, col==Cols_l, row<Rows_l: Col=0; Row+1; row_base+=RowPitch_l; Addr=row_base+RowPitch_l.
- RUN, Step=1, Last:
  - Done=1 for exactly one cycle; return to IDLE; Busy=0 in that same cycle.
  - Col, Row and Addr hold their final values.
- RUN, Step=0: all state holds.
- Abort=1 in RUN: return to IDLE next cycle, Busy=0, Done stays 0.
  - Abort has priority over Step in the same cycle.
  - Abort in IDLE has no effect.
- Start and Abort together in IDLE: Start wins.
- Cols=0 and/or Rows=0 are legal:
  - Cols=0, Rows=0: a single-position scan; Last is high in the first Busy cycle.
- Arithmetic is unsigned and wraps modulo 2^ADDR_WIDTH; no overflow flag.
- Index counters never exceed their latched bounds.
- Done and Start in the same cycle: the FSM is IDLE after Done, so the Start is accepted on the next cycle it is asserted, not the one coincident with Done.
- Throughput: one address per cycle with Step held high; a scan takes (Cols+1)*(Rows+1) Step cycles.

Test Plan:
- Reset mid-scan: Clr pulled low asynchronously between clock edges -> all outputs 0 immediately, state IDLE; after release, Step has no effect until Start.
- Basic scan: Base=100, Stride=2, RowPitch=20, Cols=2, Rows=1, Step held 1.
  - Addr sequence 100, 102, 104, 120, 122, 124.
  - Last coincident with 124; Done on the sixth Step; Busy falls.
- Step gaps and config changes: same configuration, Step toggling 1/0 -> each address held through Step=0 cycles; changing Base mid-scan does not affect the sequence.
- Degenerate and wrap cases:
  - Cols=0, Rows=0, Base=7: Addr=7, Last=1 in the first Busy cycle, Done after one Step.
  - Base=0xFFFE, Stride=1, Cols=3, Rows=0: Addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Abort: Abort and Step together at position (1,0) -> Busy=0 next cycle, no Done pulse; a new Start restarts at Base.
- Start during RUN: Start asserted mid-scan -> ignored, sequence unchanged; back-to-back scans with Start one cycle after Done both complete correctly.
